countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 155 +++++++++++++++
 tb/tb_countdown_timer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with pause/resume, preset reload and a timed alarm.
// All outputs are registered; reset is synchronous and active-high.
module countdown_timer #(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned ALARM_SECS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       pause_tgl_i,
  input  logic       load_i,
  input  logic [1:0] load_sel_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] min_l_o,
  output logic [3:0] min_r_o,
  output logic [3:0] sec_l_o,
  output logic [3:0] sec_r_o,
  output logic       running_o,
  output logic       expired_o,
  output logic       alarm_o
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AlmW = $clog2(ALARM_SECS + 1);
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);
  localparam logic [AlmW-1:0] AlmMax = AlmW'(ALARM_SECS);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  // Digit index: 3=min_l, 2=min_r, 1=sec_l, 0=sec_r.
  typedef logic [3:0][3:0] time_t;

  state_e          state_q, state_d;
  time_t           digit_q, digit_d;
  time_t           preset_q, preset_d;
  logic [DivW-1:0] div_q, div_d;
  logic [AlmW-1:0] alm_q, alm_d;
  logic            running_q, expired_q, alarm_q;
  logic            tick;
  time_t           dec;

  function automatic logic [3:0] clamp_digit(input logic [1:0] sel, input logic [3:0] val);
    logic [3:0] lim;
    lim = (sel == 2'd1) ? 4'd5 : 4'd9;
    return (val > lim) ? lim : val;
  endfunction

  // Only used while the time is non-zero, so min_l never underflows.
  function automatic time_t bcd_dec(input time_t d);
    time_t res;
    res = d;
    if (d[0] != 4'd0) begin
      res[0] = d[0] - 4'd1;
    end else begin
      res[0] = 4'd9;
      if (d[1] != 4'd0) begin
        res[1] = d[1] - 4'd1;
      end else begin
        res[1] = 4'd5;
        if (d[2] != 4'd0) begin
          res[2] = d[2] - 4'd1;
        end else begin
          res[2] = 4'd9;
          res[3] = d[3] - 4'd1;
        end
      end
    end
    return res;
  endfunction

  assign tick = (div_q == DivMax);
  assign dec  = bcd_dec(digit_q);

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    preset_d = preset_q;
    div_d    = div_q;
    alm_d    = alm_q;

    unique case (state_q)
      StIdle: begin
        // A load in the same cycle as start wins.
        if (load_i) begin
          digit_d[load_sel_i]  = clamp_digit(load_sel_i, load_val_i);
          preset_d[load_sel_i] = clamp_digit(load_sel_i, load_val_i);
        end else if (start_i && (digit_q != '0)) begin
          state_d = StRun;
          div_d   = '0;
        end
      end
      StRun: begin
        div_d = tick ? '0 : div_q + DivW'(1);
        if (tick) begin
          digit_d = dec;
        end
        if (tick && (dec == '0)) begin
          state_d = StDone;
          div_d   = '0;
          alm_d   = '0;
        end else if (pause_tgl_i) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (start_i || pause_tgl_i) begin
          state_d = StRun;
        end
      end
      StDone: begin
        div_d = tick ? '0 : div_q + DivW'(1);
        if (tick && (alm_q != AlmMax)) begin
          alm_d = alm_q + AlmW'(1);
        end
        if (start_i) begin
          state_d = StIdle;
          digit_d = preset_q;
          div_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      digit_q   <= '0;
      preset_q  <= '0;
      div_q     <= '0;
      alm_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      preset_q  <= preset_d;
      div_q     <= div_d;
      alm_q     <= alm_d;
      running_q <= (state_d == StRun);
      expired_q <= (state_d == StDone);
      alarm_q   <= (state_d == StDone) && (alm_d != AlmMax);
    end
  end

  assign min_l_o   = digit_q[3];
  assign min_r_o   = digit_q[2];
  assign sec_l_o   = digit_q[1];
  assign sec_r_o   = digit_q[0];
  assign running_o = running_q;
  assign expired_o = expired_q;
  assign alarm_o   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: seconds-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_countdown_timer;

  localparam int unsigned TD = 4;
  localparam int unsigned AS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       load = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] val = 4'd0;
  logic [3:0] min_l, min_r, sec_l, sec_r;
  logic       running, expired, alarm;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0=idle 1=run 2=pause 3=done; time held as total seconds.
  int m_mode = 0;
  int m_secs = 0;
  int m_pre[4];
  int m_ph = 0;
  int m_dc = 0;
  bit chk_en = 1'b0;

  countdown_timer #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .pause_tgl_i(pause),
    .load_i     (load),
    .load_sel_i (sel),
    .load_val_i (val),
    .min_l_o    (min_l),
    .min_r_o    (min_r),
    .sec_l_o    (sec_l),
    .sec_r_o    (sec_r),
    .running_o  (running),
    .expired_o  (expired),
    .alarm_o    (alarm)
  );

  always #5 clk = ~clk;

  function automatic int digit_of(input int s, input int idx);
    int m, sc;
    m  = s / 60;
    sc = s % 60;
    case (idx)
      3:       return m / 10;
      2:       return m % 10;
      1:       return sc / 10;
      default: return sc % 10;
    endcase
  endfunction

  function automatic int set_digit(input int s, input int idx, input int v);
    int d[4];
    for (int i = 0; i < 4; i++) d[i] = digit_of(s, i);
    d[idx] = v;
    return (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
  endfunction

  always @(posedge clk) begin : model
    int  c;
    bit  tk;
    if (rst) begin
      m_mode = 0;
      m_secs = 0;
      for (int i = 0; i < 4; i++) m_pre[i] = 0;
      m_ph = 0;
      m_dc = 0;
    end else begin
      case (m_mode)
        0: begin
          if (load) begin
            c = int'(val);
            if (sel == 2'd1 && c > 5) c = 5;
            if (c > 9) c = 9;
            m_secs = set_digit(m_secs, int'(sel), c);
            m_pre[sel] = c;
          end else if (start && m_secs != 0) begin
            m_mode = 1;
            m_ph = 0;
          end
        end
        1: begin
          tk = (m_ph == TD - 1);
          m_ph = (m_ph + 1) % TD;
          if (tk) m_secs = m_secs - 1;
          if (tk && m_secs == 0) begin
            m_mode = 3;
            m_ph = 0;
            m_dc = 0;
          end else if (pause) begin
            m_mode = 2;
          end
        end
        2: if (start || pause) m_mode = 1;
        default: begin
          if (m_dc < AS * TD) m_dc = m_dc + 1;
          if (start) begin
            m_mode = 0;
            m_secs = (m_pre[3] * 10 + m_pre[2]) * 60 + m_pre[1] * 10 + m_pre[0];
          end
        end
      endcase
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    logic [18:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = {4'(digit_of(m_secs, 3)), 4'(digit_of(m_secs, 2)), 4'(digit_of(m_secs, 1)),
               4'(digit_of(m_secs, 0)), m_mode == 1, m_mode == 3,
               (m_mode == 3) && (m_dc < AS * TD)};
      act_v = {min_l, min_r, sec_l, sec_r, running, expired, alarm};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [1:0] s, input logic [3:0] v);
    load = 1'b1; sel = s; val = v;
    step(1);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    step(1);
    pause = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] tm();
    return {16'd0, min_l, min_r, sec_l, sec_r};
  endfunction

  initial begin
    step(2);
    chk("reset_time", tm(), 32'h0000);
    chk("reset_flags", {29'd0, running, expired, alarm}, 32'd0);
    rst = 1'b0;

    // Basic countdown from 00:03 through the alarm window.
    pulse_load(2'd0, 4'd3);
    pulse_start();
    chk("run_after_start", {31'd0, running}, 32'd1);
    step(4);
    chk("cd_clk4", tm(), 32'h0002);
    step(4);
    chk("cd_clk8", tm(), 32'h0001);
    step(4);
    chk("cd_clk12", tm(), 32'h0000);
    chk("cd_clk12_flags", {29'd0, running, expired, alarm}, 32'b011);
    step(7);
    chk("alarm_clk19", {31'd0, alarm}, 32'd1);
    step(1);
    chk("alarm_clk20", {30'd0, expired, alarm}, 32'b10);
    pulse_pause();
    chk("pause_in_done", {31'd0, expired}, 32'd1);
    pulse_start();
    chk("done_reload", tm(), 32'h0003);
    chk("done_to_idle", {30'd0, expired, running}, 32'd0);

    // Start at 00:00 is ignored.
    do_reset();
    pulse_start();
    chk("start_zero", {31'd0, running}, 32'd0);

    // Clamping and load ignored while running.
    pulse_load(2'd1, 4'd7);
    chk("clamp_sec_l", {28'd0, sec_l}, 32'd5);
    pulse_load(2'd2, 4'd12);
    chk("clamp_min_r", tm(), 32'h0950);
    pulse_start();
    pulse_load(2'd3, 4'd3);
    chk("load_in_run", tm(), 32'h0950);

    // Borrow chains.
    do_reset();
    pulse_load(2'd3, 4'd1);
    pulse_start();
    step(4);
    chk("borrow_10_00", tm(), 32'h0959);
    do_reset();
    pulse_load(2'd2, 4'd1);
    pulse_start();
    step(4);
    chk("borrow_01_00", tm(), 32'h0059);

    // Pause and resume from the held divider.
    do_reset();
    pulse_load(2'd1, 4'd1);
    pulse_start();
    step(1);
    pulse_pause();
    chk("paused", {31'd0, running}, 32'd0);
    step(20);
    chk("pause_hold", tm(), 32'h0010);
    pulse_pause();
    chk("resumed", {31'd0, running}, 32'd1);
    step(1);
    chk("resume_p1", tm(), 32'h0010);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    chk("tick_and_pause", tm(), 32'h0009);
    chk("tick_and_pause_run", {31'd0, running}, 32'd0);
    pulse_start();
    chk("start_resumes", {31'd0, running}, 32'd1);

    // Expiry wins over a simultaneous pause.
    do_reset();
    pulse_load(2'd0, 4'd1);
    pulse_start();
    step(3);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    chk("done_over_pause", {29'd0, running, expired, alarm}, 32'b011);
    step(2);
    do_reset();
    chk("rst_mid_alarm", {30'd0, expired, alarm}, 32'd0);

    // Reset mid-run at 05:27.
    pulse_load(2'd2, 4'd5);
    pulse_load(2'd1, 4'd2);
    pulse_load(2'd0, 4'd7);
    pulse_start();
    step(2);
    chk("run_0527", tm(), 32'h0527);
    do_reset();
    chk("rst_mid_run_time", tm(), 32'h0000);
    chk("rst_mid_run_flags", {29'd0, running, expired, alarm}, 32'd0);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
